// File: rtl/add_sub_pkg.sv
// add_sub_pkg: shared FSM state type and mode constants for the sliced adder/subtractor
package add_sub_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic MODE_ADD = 1'b1;
  localparam logic MODE_SUB = 1'b0;
endpackage

// File: rtl/add_sub_slice.sv
// add_sub_slice: combinational CHUNK-bit add/subtract slice (b inverted when en = 0)
module add_sub_slice #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  input  logic             en,
  output logic [CHUNK-1:0] s,
  output logic             co
);
  assign {co, s} = {1'b0, a} + {1'b0, en ? b : ~b} + (CHUNK+1)'(ci);
endmodule

// File: rtl/add_sub_seq.sv
// add_sub_seq: multi-cycle WIDTH-bit add/subtract, one CHUNK slice per clock with valid/ready.
// Define ADD_SUB_OVF_EN to add the registered signed-overflow output ovf.
module add_sub_seq
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout
`ifdef ADD_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] LAST = KW'(NCHUNK - 1);
  generate
    if (NCHUNK < 1 || WIDTH % CHUNK != 0) begin : g_bad_cfg
      $error("add_sub_seq: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate
  state_t state;
  logic [WIDTH-1:0] a_r, b_r;
  logic en_r, c, co;
  logic [KW-1:0] k;
  logic [CHUNK-1:0] s;
  logic [WIDTH+CHUNK-1:0] shifted;
  // Operands shift right each RUN cycle, so the active slice is always the low CHUNK bits;
  // the result fills from the top, landing every slice in place after the last one.
  add_sub_slice #(.CHUNK(CHUNK)) u_slice (
    .a (a_r[CHUNK-1:0]),
    .b (b_r[CHUNK-1:0]),
    .ci(c),
    .en(en_r),
    .s (s),
    .co(co)
  );
  assign in_ready  = state == IDLE && !rst;
  assign out_valid = state == DONE;
  assign shifted   = {s, result};
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      result <= '0;
      cout   <= 1'b0;
`ifdef ADD_SUB_OVF_EN
      ovf    <= 1'b0;
`endif
      a_r    <= '0;
      b_r    <= '0;
      en_r   <= MODE_ADD;
      c      <= 1'b0;
      k      <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r   <= a;
          b_r   <= b;
          en_r  <= en;
          c     <= en == MODE_ADD ? cin : ~cin;
          k     <= '0;
          state <= RUN;
        end
        RUN: begin
          a_r    <= a_r >> CHUNK;
          b_r    <= b_r >> CHUNK;
          result <= shifted[WIDTH+CHUNK-1:CHUNK];
          c      <= co;
          k      <= k + 1'b1;
          if (k == LAST) begin
            cout  <= en_r == MODE_ADD ? co : ~co;
`ifdef ADD_SUB_OVF_EN
            ovf   <= (a_r[CHUNK-1] == (en_r ? b_r[CHUNK-1] : ~b_r[CHUNK-1])) && (s[CHUNK-1] != a_r[CHUNK-1]);
`endif
            state <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
